// File: rtl/uart_rx_fifo_param.sv
// UART receiver with an integrated circular receive FIFO.
// Serial input is synchronized, frames are decoded by a small FSM whose bit
// timing comes from a down-counter, and each good word is pushed into the
// FIFO. Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AE_THRESH    = 1,
    parameter int AF_THRESH    = DEPTH - 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       rx_en,
    input  logic                       rx_serial_data,
    input  logic                       rd_en,
    input  logic                       err_clr,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       empty,
    output logic                       almost_empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     data_count,
    output logic                       frame_err,
    output logic                       overflow,
    output logic                       parity_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q, prev_q;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    wr_q, wr_d;
    logic                    frame_set;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    empty_q, empty_d, ae_q, ae_d, full_q, full_d, af_q, af_d;
    logic                    frame_err_q, frame_err_d, overflow_q, overflow_d;
    logic                    rd_ok, wr_ok, fall, tick;
`ifdef UART_RX_PARITY_EN
    logic                    par_bad_q, par_bad_d, par_set, parity_err_q, parity_err_d;
`endif

    assign fall = prev_q & ~sync2_q;
    assign tick = (tmr_q == '0);

    // Frame decoder: next state, bit timer, shift register and write request.
    always_comb begin
        state_d   = state_q;
        tmr_d     = (tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        wr_d      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    tmr_d   = HALF_M1;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    // A high line at mid start bit is a glitch, not a frame.
                    if (sync2_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        tmr_d   = FULL_M1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {sync2_q, shift_q[DATA_WIDTH-1:1]};
                    tmr_d   = FULL_M1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    tmr_d   = FULL_M1;
                    if (((^shift_q) ^ sync2_q) != PARITY_ODD) begin
                        par_bad_d = 1'b1;
                        par_set   = 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    if (sync2_q) begin
`ifdef UART_RX_PARITY_EN
                        wr_d = ~par_bad_q;
`else
                        wr_d = 1'b1;
`endif
                    end else begin
                        frame_set = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Disabling the receiver silently abandons any frame in flight.
        if (!rx_en) begin
            state_d   = S_IDLE;
            wr_d      = 1'b0;
            frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_set   = 1'b0;
`endif
        end
    end

    // FIFO bookkeeping, registered status flags and sticky error flags.
    always_comb begin
        rd_ok    = rd_en & ~empty_q;
        wr_ok    = wr_q & (~full_q | rd_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            dout_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
        empty_d     = (count_d == '0);
        full_d      = (count_d == DEPTH_C);
        ae_d        = (count_d <= AE_C);
        af_d        = (count_d >= AF_C);
        frame_err_d = err_clr ? 1'b0 : (frame_err_q | frame_set);
        overflow_d  = err_clr ? 1'b0 : (overflow_q | (wr_q & full_q & ~rd_ok));
`ifdef UART_RX_PARITY_EN
        parity_err_d = err_clr ? 1'b0 : (parity_err_q | par_set);
`endif
    end

    // All state registers; reset clears the FIFO and drops any frame.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            wr_q        <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            empty_q     <= 1'b1;
            ae_q        <= 1'b1;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= rx_serial_data;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_q        <= wr_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            empty_q     <= empty_d;
            ae_q        <= ae_d;
            full_q      <= full_d;
            af_q        <= af_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign dout         = dout_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign data_count   = count_q;
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = parity_err_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench for uart_rx_fifo_param (CLKS_PER_BIT=16, 8 data bits, DEPTH=16).
module tb_uart_rx_fifo_param;
    localparam int CPB   = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Edge (counted from the edge after which the start bit begins) that commits the write.
    localparam int WR_EDGE = 12 + CPB * (NB - 1);

    logic          clk_in = 1'b0;
    logic          rst, rx_en, rx_serial_data, rd_en, err_clr;
    logic [DW-1:0] dout;
    logic          empty, almost_empty, full, almost_full;
    logic [4:0]    data_count;
    logic          frame_err, overflow, parity_err;
    int            n_pass = 0;
    int            n_total = 0;

    always #5 clk_in = ~clk_in;

    uart_rx_fifo_param #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .AE_THRESH(1),
        .AF_THRESH(DEPTH - 1)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .rx_en(rx_en),
        .rx_serial_data(rx_serial_data),
        .rd_en(rd_en),
        .err_clr(err_clr),
        .dout(dout),
        .empty(empty),
        .almost_empty(almost_empty),
        .full(full),
        .almost_full(almost_full),
        .data_count(data_count),
        .frame_err(frame_err),
        .overflow(overflow),
        .parity_err(parity_err)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_serial_data = bits[i];
            wait_cyc(CPB);
        end
    endtask

    function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic stop_b,
                                               input logic par_flip);
        logic [15:0] b;
`ifdef UART_RX_PARITY_EN
        b = {5'b11111, stop_b, (^d) ^ par_flip, d, 1'b0};
`else
        b = {6'b111111, stop_b, d, 1'b0};
        if (par_flip) b[0] = 1'b0;
`endif
        return b;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        send_bits(frame_bits(d, stop_b, par_flip), NB);
        rx_serial_data = 1'b1;
        wait_cyc(4);
    endtask

    task automatic read_word();
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        n_total++; if (dout !== 8'h00) $display("FAIL rst_dout: got %h expected 00", dout); else n_pass++;
        n_total++; if (data_count !== 5'd0) $display("FAIL rst_count: got %0d expected 0", data_count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b expected 1", empty); else n_pass++;
        n_total++; if (almost_empty !== 1'b1) $display("FAIL rst_ae: got %b expected 1", almost_empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL rst_full: got %b expected 0", full); else n_pass++;
        n_total++; if (almost_full !== 1'b0) $display("FAIL rst_af: got %b expected 0", almost_full); else n_pass++;
        n_total++; if ({frame_err, overflow, parity_err} !== 3'b000)
            $display("FAIL rst_errs: got %b expected 000", {frame_err, overflow, parity_err}); else n_pass++;
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b1, 1'b0);
        n_total++; if (data_count !== 5'd1) $display("FAIL a5_count: got %0d expected 1", data_count); else n_pass++;
        n_total++; if (empty !== 1'b0) $display("FAIL a5_empty: got %b expected 0", empty); else n_pass++;
        n_total++; if (almost_empty !== 1'b1) $display("FAIL a5_ae: got %b expected 1", almost_empty); else n_pass++;
        read_word();
        n_total++; if (dout !== 8'hA5) $display("FAIL a5_dout: got %h expected a5", dout); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL a5_empty_after: got %b expected 1", empty); else n_pass++;
        read_word();
        n_total++; if (dout !== 8'hA5) $display("FAIL empty_read_hold: got %h expected a5", dout); else n_pass++;
        n_total++; if (data_count !== 5'd0) $display("FAIL empty_read_count: got %0d expected 0", data_count); else n_pass++;
    endtask

    task automatic test_glitch();
        rx_serial_data = 1'b0;
        wait_cyc(4);
        rx_serial_data = 1'b1;
        wait_cyc(40);
        n_total++; if (data_count !== 5'd0) $display("FAIL glitch_count: got %0d expected 0", data_count); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL glitch_ferr: got %b expected 0", frame_err); else n_pass++;
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0);
        n_total++; if (frame_err !== 1'b1) $display("FAIL ferr_set: got %b expected 1", frame_err); else n_pass++;
        n_total++; if (data_count !== 5'd0) $display("FAIL ferr_count: got %0d expected 0", data_count); else n_pass++;
        pulse_err_clr();
        n_total++; if (frame_err !== 1'b0) $display("FAIL ferr_clr: got %b expected 0", frame_err); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            if (i == 1) begin
                n_total++; if (almost_empty !== 1'b0) $display("FAIL fill_ae2: got %b expected 0", almost_empty); else n_pass++;
            end
            if (i == 14) begin
                n_total++; if (almost_full !== 1'b1) $display("FAIL fill_af15: got %b expected 1", almost_full); else n_pass++;
                n_total++; if (full !== 1'b0) $display("FAIL fill_full15: got %b expected 0", full); else n_pass++;
            end
            if (i == 15) begin
                n_total++; if (full !== 1'b1) $display("FAIL fill_full16: got %b expected 1", full); else n_pass++;
                n_total++; if (overflow !== 1'b0) $display("FAIL fill_ovf16: got %b expected 0", overflow); else n_pass++;
            end
        end
        n_total++; if (overflow !== 1'b1) $display("FAIL fill_ovf17: got %b expected 1", overflow); else n_pass++;
        n_total++; if (data_count !== 5'd16) $display("FAIL fill_count17: got %0d expected 16", data_count); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            read_word();
            n_total++; if (dout !== 8'(i)) $display("FAIL fill_rd%0d: got %h expected %h", i, dout, 8'(i)); else n_pass++;
            if (i == 0) begin
                n_total++; if (full !== 1'b0) $display("FAIL fill_full_after_rd: got %b expected 0", full); else n_pass++;
            end
        end
        n_total++; if (empty !== 1'b1) $display("FAIL fill_drained: got %b expected 1", empty); else n_pass++;
        pulse_err_clr();
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clr: got %b expected 0", overflow); else n_pass++;
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 1'b0);
        fork
            send_frame(8'h5A, 1'b1, 1'b0);
            begin
                wait_cyc(WR_EDGE - 1);
                rd_en = 1'b1;
                wait_cyc(1);
                rd_en = 1'b0;
                n_total++; if (data_count !== 5'd1) $display("FAIL rw_count: got %0d expected 1", data_count); else n_pass++;
                n_total++; if (dout !== 8'h11) $display("FAIL rw_dout: got %h expected 11", dout); else n_pass++;
            end
        join
        read_word();
        n_total++; if (dout !== 8'h5A) $display("FAIL rw_second: got %h expected 5a", dout); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL rw_empty: got %b expected 1", empty); else n_pass++;
    endtask

    task automatic test_abort();
        send_bits(frame_bits(8'h77, 1'b1, 1'b0), 4);
        rx_en = 1'b0;
        send_bits(frame_bits(8'h77, 1'b1, 1'b0) >> 4, NB - 4);
        rx_serial_data = 1'b1;
        wait_cyc(4);
        rx_en = 1'b1;
        wait_cyc(4);
        n_total++; if (data_count !== 5'd0) $display("FAIL abort_count: got %0d expected 0", data_count); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL abort_ferr: got %b expected 0", frame_err); else n_pass++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h01, 1'b1, 1'b1);
        n_total++; if (parity_err !== 1'b1) $display("FAIL par_bad_flag: got %b expected 1", parity_err); else n_pass++;
        n_total++; if (data_count !== 5'd0) $display("FAIL par_bad_count: got %0d expected 0", data_count); else n_pass++;
        pulse_err_clr();
        send_frame(8'h01, 1'b1, 1'b0);
        n_total++; if (parity_err !== 1'b0) $display("FAIL par_ok_flag: got %b expected 0", parity_err); else n_pass++;
        read_word();
        n_total++; if (dout !== 8'h01) $display("FAIL par_ok_dout: got %h expected 01", dout); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_frame();
        send_frame(8'h22, 1'b1, 1'b0);
        n_total++; if (data_count !== 5'd1) $display("FAIL prerst_count: got %0d expected 1", data_count); else n_pass++;
        send_bits(frame_bits(8'h55, 1'b1, 1'b0), 4);
        rst = 1'b1;
        #2;
        n_total++; if (dout !== 8'h00) $display("FAIL midrst_dout: got %h expected 00", dout); else n_pass++;
        n_total++; if (data_count !== 5'd0) $display("FAIL midrst_count: got %0d expected 0", data_count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL midrst_empty: got %b expected 1", empty); else n_pass++;
        rx_serial_data = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(4);
        send_frame(8'h96, 1'b1, 1'b0);
        n_total++; if (data_count !== 5'd1) $display("FAIL postrst_count: got %0d expected 1", data_count); else n_pass++;
        read_word();
        n_total++; if (dout !== 8'h96) $display("FAIL postrst_dout: got %h expected 96", dout); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL postrst_ferr: got %b expected 0", frame_err); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        rx_en = 1'b1;
        rx_serial_data = 1'b1;
        rd_en = 1'b0;
        err_clr = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_fill();
        test_back_to_back();
        test_abort();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_param.md
# uart_rx_fifo_param

Parametrised UART receiver with an integrated synchronous receive FIFO. Decodes asynchronous serial frames (configurable data width, optional parity), detects framing and overflow errors, and buffers received words in an internal DEPTH-entry FIFO for a downstream consumer. Drop-in successor to the fixed 8-bit receive path. Unlike that path, it carries its own bit-timing engine, error reporting and parametrised storage, and depends on no vendor FIFO IP.

## Interface
- CLKS_PER_BIT, 16: clk_in cycles per serial bit; must be ≥ 4.
- DATA_WIDTH, 8: data bits per frame, 5..9.
- DEPTH, 16: FIFO entries; power of two, ≥ 4.
- AE_THRESH, 1: almost_empty asserted when data_count ≤ AE_THRESH.
- AF_THRESH, DEPTH-1: almost_full asserted when data_count ≥ AF_THRESH.

Ports:
- clk_in  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_en  in  1  receiver enable; low forces the FSM to IDLE.
- rx_serial_data  in  1  asynchronous serial line, idle high.
- rd_en  in  1  FIFO read request.
- err_clr  in  1  one-cycle pulse; clears all sticky error flags.
- dout  out  DATA_WIDTH  registered FIFO read data.
- empty / almost_empty / full / almost_full  out  1  FIFO status.
- data_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- frame_err / overflow / parity_err  out  1  sticky error flags.

## Operation
- rx_serial_data passes through a 2-flop synchronizer (reset value 1) before use.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE → START on a synchronized falling edge while rx_en=1. The bit counter resets to 0.
- START: sample at CLKS_PER_BIT/2. Line high means a glitch: return to IDLE with no error. Line low: go to DATA.
- DATA: sample every CLKS_PER_BIT cycles, LSB first, into a DATA_WIDTH shift register. After DATA_WIDTH bits, go to PARITY or STOP.
- STOP: sample the stop bit.
  - Stop bit high and no parity error: issue a one-cycle internal write.
  - Stop bit low: set frame_err and discard the word.
  - Either case: return to IDLE.
- rx_en falling mid-frame aborts the frame: no write, no error.
- FIFO is a circular buffer with $clog2(DEPTH)-bit wrapping pointers.
- Write accepted when not full, or when full and a read is accepted in the same cycle. A write into a full FIFO with no read sets overflow, and the word is dropped.
- Read accepted when rd_en=1 and not empty. rd_en on an empty FIFO is ignored and dout holds.
- Simultaneous read and write: both are accepted and data_count is unchanged. On an empty FIFO the write is accepted and the read is ignored.
- err_clr has priority over a same-cycle error set: flags read 0 next cycle.

## Timing
- Reset values: dout=0, data_count=0, empty=1, almost_empty=1, full=0, almost_full=0, all error flags 0, FSM=IDLE.
- Reset is asynchronous: outputs take reset values immediately, and any frame in progress is lost.
- Line-to-detection latency: 2 cycles (synchronizer) + 1 cycle (edge detect).
- Write occurs on the cycle after the stop-bit sample.
- data_count, empty/full and the almost_* flags are registered and update on the edge that commits the write or read.
- Read latency: dout is valid 1 cycle after the accepted rd_en.
- Error flags set on the cycle after the offending sample or write attempt.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state is present, and one parity bit follows the data bits.
  - Parameter PARITY_ODD (default 0 = even) selects the parity sense.
  - A mismatch sets parity_err and discards the word.
- Undefined: no parity bit, and STOP follows DATA directly. parity_err is tied to 0.

## Test plan
- Send 0xA5 at CLKS_PER_BIT=16 → data_count=1, empty=0; then pulse rd_en → dout=0xA5 one cycle later, empty=1.
- Send 17 frames 0x00..0x10 at DEPTH=16 with no reads → full=1 after the 16th and overflow=1 after the 17th; 16 reads return 0x00..0x0F.
- Send 0x3C with the stop bit forced low → frame_err=1, data_count stays 0; err_clr → frame_err=0.
- Drive a 4-cycle low glitch on an idle line → no write, no error flag, FSM back in IDLE.
- With UART_RX_PARITY_EN and even parity: send 0x01 with parity bit 0 → parity_err=1, discarded. Send 0x01 with parity bit 1 → accepted.
- Assert rst mid-DATA of 0x55 → outputs at reset values immediately. The next frame, 0x96, is received intact.
